// File: rtl/mem_wb_stage_if.sv
// MEM/WB boundary bus: MEM-stage results and controls in, writeback-bus
// signals, forwarding select and retirement count out.
interface mem_wb_stage_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
);
  // Pipeline control
  logic                 stall_w;
  logic                 flush_w;
  // MEM-stage instruction
  logic                 valid_m;
  logic                 reg_write_m;
  logic                 mem_write_m;
  logic [1:0]           result_src_m;
  logic [2:0]           funct3_m;
  logic [4:0]           rd_m;
  logic [4:0]           rs2_m;
  logic [WIDTH-1:0]     alu_result_m;
  logic [WIDTH-1:0]     read_data_m;
  logic [WIDTH-1:0]     pc_plus4_m;
  // Writeback side
  logic [WIDTH-1:0]     result_w;
  logic [4:0]           rd_w;
  logic                 reg_write_w;
  logic                 fwd_ls_w;
  logic                 misaligned_w;
  logic [CNT_WIDTH-1:0] instret_w;

  // Driver of MEM results, consumer of writeback outputs
  modport master (
    output stall_w, flush_w, valid_m, reg_write_m, mem_write_m, result_src_m,
           funct3_m, rd_m, rs2_m, alu_result_m, read_data_m, pc_plus4_m,
    input  result_w, rd_w, reg_write_w, fwd_ls_w, misaligned_w, instret_w
  );

  // The MEM/WB stage itself
  modport slave (
    input  stall_w, flush_w, valid_m, reg_write_m, mem_write_m, result_src_m,
           funct3_m, rd_m, rs2_m, alu_result_m, read_data_m, pc_plus4_m,
    output result_w, rd_w, reg_write_w, fwd_ls_w, misaligned_w, instret_w
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction, writeback select,
// load-to-store forwarding select and a retired-instruction counter.
// Byte-lane logic assumes WIDTH == 32.
module mem_wb_stage #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_wb_stage_if.slave bus
);

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LOAD = 2'b01,
    SRC_PC4  = 2'b10,
    SRC_NONE = 2'b11
  } result_src_e;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic [4:0]       rd;
    result_src_e      result_src;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] pc_plus4;
  } wb_regs_t;

  wb_regs_t             wb_q;
  wb_regs_t             wb_d;
  logic [CNT_WIDTH-1:0] instret_q;

  logic             advance;
  logic [1:0]       off;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [WIDTH-1:0] load_data;
  logic             load_bad;
  logic             misaligned;
  logic             reg_write;

  assign advance = !bus.flush_w && !bus.stall_w;

  // Next stage-register contents: flush beats stall, stall holds, else capture
  always_comb begin
    // NOTE: default to the held value first so every path assigns wb_d and no latch is inferred.
    wb_d = wb_q;
    if (bus.flush_w) begin
      wb_d = '0;
    end else if (!bus.stall_w) begin
      wb_d.valid      = bus.valid_m;
      wb_d.reg_write  = bus.reg_write_m & bus.valid_m;
      wb_d.rd         = bus.rd_m;
      wb_d.result_src = result_src_e'(bus.result_src_m);
      wb_d.funct3     = bus.funct3_m;
      wb_d.alu_result = bus.alu_result_m;
      wb_d.read_data  = bus.read_data_m;
      wb_d.pc_plus4   = bus.pc_plus4_m;
    end
  end

  // Stage register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: data fields are cleared too (not just valid) so every output reads 0 during reset.
    if (rst) begin
      wb_q <= '0;
    end else begin
      // NOTE: non-blocking assignment so all flops update together on the edge.
      wb_q <= wb_d;
    end
  end

  // Retired-instruction counter: counts valid instructions entering WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (advance && bus.valid_m) begin
      instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  // Load lane extraction, sign/zero extension and alignment check
  always_comb begin
    off       = wb_q.alu_result[1:0];
    byte_sel  = wb_q.read_data[{off, 3'b000} +: 8];
    half_sel  = wb_q.read_data[{off[1], 4'b0000} +: 16];
    load_data = '0;
    load_bad  = 1'b0;
    unique case (wb_q.funct3)
      3'b000: load_data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b100: load_data = {{(WIDTH-8){1'b0}}, byte_sel};
      3'b001: begin
        if (off[0]) load_bad = 1'b1;
        else        load_data = {{(WIDTH-16){half_sel[15]}}, half_sel};
      end
      3'b101: begin
        if (off[0]) load_bad = 1'b1;
        else        load_data = {{(WIDTH-16){1'b0}}, half_sel};
      end
      3'b010: begin
        if (off != 2'b00) load_bad = 1'b1;
        else              load_data = wb_q.read_data;
      end
      default: load_bad = 1'b1;
    endcase
  end

  assign misaligned = wb_q.valid && (wb_q.result_src == SRC_LOAD) && load_bad;
  assign reg_write  = wb_q.reg_write && !misaligned;

  // Writeback result select
  always_comb begin
    bus.result_w = '0;
    unique case (wb_q.result_src)
      SRC_ALU:  bus.result_w = wb_q.alu_result;
      SRC_LOAD: bus.result_w = load_data;
      SRC_PC4:  bus.result_w = wb_q.pc_plus4;
      SRC_NONE: bus.result_w = '0;
    endcase
  end

  assign bus.rd_w         = wb_q.rd;
  assign bus.reg_write_w  = reg_write;
  assign bus.misaligned_w = misaligned;
  assign bus.instret_w    = instret_q;

  // Store in MEM reads the register WB is about to write: forward result_w
  assign bus.fwd_ls_w = bus.mem_write_m && bus.valid_m && reg_write &&
                        (wb_q.rd != 5'd0) && (wb_q.rd == bus.rs2_m);

endmodule
